// File: rtl/water_tile_scroll_ctrl.sv
// Water tile ROM address scheduler: tiles a scrolling, animated texture across the raster.
// Optional animation divider and frame cycling enabled by defining WATER_ANIM_EN.
module water_tile_scroll_ctrl #(
  parameter int TILE_W     = 96,
  parameter int TILE_H     = 96,
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_speed,
  input  logic              cfg_enable,
  output logic [ADDR_W-1:0] rom_address,
  output logic              pix_valid,
  output logic [6:0]        scroll_x,
  output logic [1:0]        anim_frame
);

  generate
    if (NUM_FRAMES * TILE_W * TILE_H > (1 << ADDR_W) || ANIM_DIV < 1) begin : g_bad_cfg
      $error("water_tile_scroll_ctrl: parameters do not fit the ROM address space");
    end
  endgenerate

  typedef enum logic {IDLE, PENDING} cfg_state_t;

  cfg_state_t  state_q, state_d;
  logic        frame_start_q;
  logic        tick;
  logic        accept, apply;
  logic [3:0]  act_speed, pend_speed;
  logic        act_en, pend_en;
  logic [1:0]  blank_q;
  logic [7:0]  scroll_sum;
  logic [6:0]  scroll_nxt;
  logic [10:0] sum_x;
  logic [6:0]  tx, ty;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] addr_d;

  assign tick = frame_start & ~frame_start_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // An offer accepted in IDLE never sees apply in the same cycle, so a coincident tick uses the old values.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (tick) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scroll_sum = {1'b0, scroll_x} + {4'b0, act_speed};
  assign scroll_nxt = (scroll_sum >= 8'(TILE_W)) ? 7'(scroll_sum - 8'(TILE_W)) : scroll_sum[6:0];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_q <= 1'b0;
      scroll_x      <= '0;
      act_speed     <= 4'd1;
      act_en        <= 1'b1;
      pend_speed    <= '0;
      pend_en       <= 1'b0;
    end else begin
      frame_start_q <= frame_start;
      if (tick && act_en) scroll_x <= scroll_nxt;
      if (accept) begin
        pend_speed <= cfg_speed;
        pend_en    <= cfg_enable;
      end
      if (apply) begin
        act_speed <= pend_speed;
        act_en    <= pend_en;
      end
    end
  end

`ifdef WATER_ANIM_EN
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      anim_frame <= '0;
    end else if (tick && act_en) begin
      if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_q      <= '0;
        anim_frame <= (anim_frame == 2'(NUM_FRAMES - 1)) ? '0 : anim_frame + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign frame_base = ADDR_W'(anim_frame) * ADDR_W'(TILE_W * TILE_H);
`else
  assign anim_frame = '0;
  assign frame_base = '0;
`endif

  assign sum_x  = {1'b0, DrawX} + {4'b0, scroll_x};
  assign tx     = 7'(sum_x % 11'(TILE_W));
  assign ty     = 7'(DrawY % 10'(TILE_H));
  assign addr_d = frame_base + ADDR_W'(ty) * ADDR_W'(TILE_W) + ADDR_W'(tx);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      blank_q     <= '0;
    end else begin
      rom_address <= addr_d;
      blank_q     <= {blank_q[0], blank};
    end
  end

  assign pix_valid = blank_q[1];

endmodule

// File: tb/tb_water_tile_scroll_ctrl.sv
// Directed bench for water_tile_scroll_ctrl: reset, scroll wrap, animation, freeze, handshake, held frame_start.
// Anim-dependent expectations follow WATER_ANIM_EN.
module tb_water_tile_scroll_ctrl;

`ifdef WATER_ANIM_EN
  localparam int ANIM_ON = 1;
`else
  localparam int ANIM_ON = 0;
`endif
  localparam int FRAME_WORDS = 96 * 96;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start;
  logic        cfg_valid, cfg_ready, cfg_enable;
  logic [3:0]  cfg_speed;
  logic [15:0] rom_address;
  logic        pix_valid;
  logic [6:0]  scroll_x;
  logic [1:0]  anim_frame;

  int n_checks = 0;
  int n_pass   = 0;

  water_tile_scroll_ctrl #(.TILE_W(96), .TILE_H(96), .NUM_FRAMES(4), .ANIM_DIV(8), .ADDR_W(16)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_speed   (cfg_speed),
    .cfg_enable  (cfg_enable),
    .rom_address (rom_address),
    .pix_valid   (pix_valid),
    .scroll_x    (scroll_x),
    .anim_frame  (anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int exp_anim(input int frame);
    return ANIM_ON ? frame : 0;
  endfunction

  task automatic do_tick();
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic offer(input logic [3:0] spd, input logic en);
    cfg_valid  = 1'b1;
    cfg_speed  = spd;
    cfg_enable = en;
    @(negedge vga_clk);
    cfg_valid  = 1'b0;
  endtask

  task automatic addr_at(input int x, input int y, input string tag, input int exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge vga_clk);
    check(tag, int'(rom_address), exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    cfg_valid = 1'b0; cfg_speed = '0; cfg_enable = 1'b0;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;

    // Build up state, leave a pending config, then reset asynchronously mid-frame.
    ticks(2);
    blank = 1'b1;
    offer(4'd9, 1'b1);
    check("ready_after_accept", int'(cfg_ready), 0);
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_rom_address", int'(rom_address), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_scroll_x", int'(scroll_x), 0);
    check("rst_anim_frame", int'(anim_frame), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    blank = 1'b0;
    ticks(2);
    check("rst_pending_cleared", int'(scroll_x), 2);

    reset_n = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    addr_at(100, 200, "addr_100_200", 772);

    blank = 1'b1;
    @(negedge vga_clk); check("pix_rise_d1", int'(pix_valid), 0);
    @(negedge vga_clk); check("pix_rise_d2", int'(pix_valid), 1);
    blank = 1'b0;
    @(negedge vga_clk); check("pix_fall_d1", int'(pix_valid), 1);
    @(negedge vga_clk); check("pix_fall_d2", int'(pix_valid), 0);

    // Animation: 8 ticks at speed 1 -> scroll 8, frame 1.
    ticks(8);
    check("anim_8_scroll", int'(scroll_x), 8);
    check("anim_8_frame", int'(anim_frame), exp_anim(1));
    addr_at(92, 200, "anim_8_addr", exp_anim(1) * FRAME_WORDS + 772);
    ticks(24);
    check("anim_32_frame", int'(anim_frame), 0);
    check("anim_32_scroll", int'(scroll_x), 32);

    // Scroll wrap: reach 94 at speed 3, then 94+3 wraps to 1.
    ticks(1);
    offer(4'd3, 1'b1);
    do_tick();
    check("apply_old_speed", int'(scroll_x), 34);
    ticks(20);
    check("wrap_pre", int'(scroll_x), 94);
    do_tick();
    check("wrap_post", int'(scroll_x), 1);
    check("wrap_anim", int'(anim_frame), exp_anim(2));
    addr_at(0, 0, "wrap_addr", exp_anim(2) * FRAME_WORDS + 1);

    // Freeze: applying tick still moves by 3, then everything holds.
    offer(4'd3, 1'b0);
    do_tick();
    check("freeze_apply_scroll", int'(scroll_x), 4);
    check("freeze_apply_anim", int'(anim_frame), exp_anim(3));
    ticks(5);
    check("freeze_scroll", int'(scroll_x), 4);
    check("freeze_anim", int'(anim_frame), exp_anim(3));

    // Handshake: held offer of speed 5, then a second offer that must stall.
    cfg_valid = 1'b1; cfg_speed = 4'd5; cfg_enable = 1'b1;
    @(negedge vga_clk);
    check("hs_ready_low", int'(cfg_ready), 0);
    cfg_speed = 4'd7;
    repeat (3) @(negedge vga_clk);
    check("hs_stall", int'(cfg_ready), 0);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    check("hs_frozen_tick", int'(scroll_x), 4);
    check("hs_ready_high", int'(cfg_ready), 1);
    @(negedge vga_clk);
    cfg_valid = 1'b0;
    check("hs_second_accept", int'(cfg_ready), 0);
    do_tick();
    check("hs_speed5", int'(scroll_x), 9);

    // Same-cycle accept and tick: tick uses 7, next tick still 7, then 2.
    cfg_valid = 1'b1; cfg_speed = 4'd2; frame_start = 1'b1;
    @(negedge vga_clk);
    cfg_valid = 1'b0; frame_start = 1'b0;
    check("same_cycle_scroll", int'(scroll_x), 16);
    check("same_cycle_ready", int'(cfg_ready), 0);
    @(negedge vga_clk);
    do_tick();
    check("same_cycle_next", int'(scroll_x), 23);
    do_tick();
    check("same_cycle_new_speed", int'(scroll_x), 25);

    // frame_start level held for 10 cycles: one step only.
    frame_start = 1'b1;
    repeat (10) @(negedge vga_clk);
    frame_start = 1'b0;
    @(negedge vga_clk);
    check("held_fs_scroll", int'(scroll_x), 27);
    check("held_fs_anim", int'(anim_frame), exp_anim(3));
    addr_at(0, 95, "final_addr", exp_anim(3) * FRAME_WORDS + 9147);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
